// File: rtl/apo_router_input_arbiter.sv
// ----------------------------------------------------------------------------
// apo_router_input_arbiter
//   Input stage in front of a circulant router. The router takes only one
//   packet per clock, so this block buffers the five input streams in
//   per-port FIFOs. Each cycle it forwards at most one packet, picked
//   round-robin, onto the router input with the same index.
//
//   Port index order: 0 free, 1 r1R, 2 r2R, 3 r1L, 4 r2L.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_*   [N2-1:0]       input packets, bit N2-1 = valid flag
//   out_*  [N2-1:0]       registered router inputs, at most one non-zero
//   fifo_empty [4:0]      registered per-port empty flags {r2L,r1L,r2R,r1R,free}
//   ovf [4:0]             one-cycle pulse per port when a packet was dropped
//   drop_cnt [CNT_W-1:0]  saturating total of dropped packets
// ----------------------------------------------------------------------------

// Per-port FIFO with its own registered output slot. The output register
// carries the popped head for one cycle and is zero otherwise.
module apo_arb_fifo #(
   parameter int N2    = 17,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [N2-1:0]              i_din,
   output logic [$clog2(DEPTH):0]     o_cnt,
   output logic                       o_empty,
   output logic [N2-1:0]              o_out
);
   localparam int AW = $clog2(DEPTH);

   logic [N2-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt, w_cnt_nxt;
   logic          r_empty;
   logic [N2-1:0] r_out;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_push && !i_pop)      w_cnt_nxt = r_cnt + 1'b1;
      else if (!i_push && i_pop) w_cnt_nxt = r_cnt - 1'b1;
   end

   // Storage has no reset; the pointers and count define what is live.
   // A push into a full FIFO that is popped on the same edge writes the
   // slot being read; the non-blocking read still returns the old head.
   always_ff @(posedge clk) begin
      if (!rst && i_push) r_mem[r_wp] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         r_empty <= 1'b1;
         r_out   <= '0;
      end else begin
         if (i_push) r_wp <= r_wp + 1'b1;
         if (i_pop) begin
            r_rp  <= r_rp + 1'b1;
            r_out <= r_mem[r_rp];
         end else begin
            r_out <= '0;
         end
         r_cnt   <= w_cnt_nxt;
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   assign o_cnt   = r_cnt;
   assign o_empty = r_empty;
   assign o_out   = r_out;
endmodule

module apo_router_input_arbiter #(
   parameter int N2    = 17,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N2-1:0]    in_free,
   input  logic [N2-1:0]    in_r1R,
   input  logic [N2-1:0]    in_r2R,
   input  logic [N2-1:0]    in_r1L,
   input  logic [N2-1:0]    in_r2L,
   output logic [N2-1:0]    out_free,
   output logic [N2-1:0]    out_r1R,
   output logic [N2-1:0]    out_r2R,
   output logic [N2-1:0]    out_r1L,
   output logic [N2-1:0]    out_r2L,
   output logic [4:0]       fifo_empty,
   output logic [4:0]       ovf,
   output logic [CNT_W-1:0] drop_cnt
);
   localparam int          NP   = 5;
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [NP-1:0][N2-1:0] w_in, w_out;
   logic [AW:0]           w_cnt [NP];
   logic [NP-1:0]         w_ne, w_empty, w_pop, w_push, w_drop;
   logic                  w_gvld;
   logic [2:0]            w_gidx;
   logic [3:0]            w_t;
   logic [2:0]            w_ndrop;
   logic [CNT_W:0]        w_dsum;

   logic [2:0]            r_rr;
   logic [NP-1:0]         r_ovf;
   logic [CNT_W-1:0]      r_drop;

   assign w_in = {in_r2L, in_r1L, in_r2R, in_r1R, in_free};

   // Round-robin search from r_rr upward mod 5. Walking k downward lets the
   // smallest offset overwrite, so the first non-empty port found wins.
   always_comb begin
      w_gvld = 1'b0;
      w_gidx = '0;
      w_t    = '0;
      for (int k = NP-1; k >= 0; k--) begin
         w_t = {1'b0, r_rr} + 4'(k);
         if (w_t >= 4'd5) w_t = w_t - 4'd5;
         if (w_ne[w_t[2:0]]) begin
            w_gvld = 1'b1;
            w_gidx = w_t[2:0];
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < NP; g++) begin : g_port
         assign w_ne[g]   = (w_cnt[g] != '0);
         assign w_pop[g]  = w_gvld && (w_gidx == 3'(g));
         // Full FIFO still accepts when the same edge pops it.
         assign w_push[g] = w_in[g][N2-1] && ((w_cnt[g] != FULL) || w_pop[g]);
         assign w_drop[g] = w_in[g][N2-1] && !w_push[g];

         apo_arb_fifo #(.N2(N2), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_din   (w_in[g]),
            .o_cnt   (w_cnt[g]),
            .o_empty (w_empty[g]),
            .o_out   (w_out[g])
         );
      end
   endgenerate

   always_comb begin
      w_ndrop = '0;
      for (int i = 0; i < NP; i++) w_ndrop = w_ndrop + 3'(w_drop[i]);
   end

   // One extra bit catches the carry that signals saturation.
   assign w_dsum = {1'b0, r_drop} + (CNT_W+1)'(w_ndrop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr   <= '0;
         r_ovf  <= '0;
         r_drop <= '0;
      end else begin
         if (w_gvld) r_rr <= (w_gidx == 3'd4) ? 3'd0 : w_gidx + 3'd1;
         r_ovf  <= w_drop;
         r_drop <= w_dsum[CNT_W] ? {CNT_W{1'b1}} : w_dsum[CNT_W-1:0];
      end
   end

   assign out_free   = w_out[0];
   assign out_r1R    = w_out[1];
   assign out_r2R    = w_out[2];
   assign out_r1L    = w_out[3];
   assign out_r2L    = w_out[4];
   assign fifo_empty = w_empty;
   assign ovf        = r_ovf;
   assign drop_cnt   = r_drop;
endmodule

// File: tb/tb_apo_router_input_arbiter.sv
module tb_apo_router_input_arbiter;
   localparam int N2    = 17;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] din  [5];
   logic [16:0] dout [5];
   logic [4:0]  fifo_empty, ovf;
   logic [7:0]  drop_cnt;

   int npass = 0;
   int ntot  = 0;

   // Reference model: per-port queues of accepted packets. Packets are
   // pushed when driven and popped when the DUT is expected to forward them.
   logic [16:0] mq [5][$];
   int          rr;
   logic [16:0] eout [5];
   logic [4:0]  eovf;
   int          edrop;

   always #5 clk = ~clk;

   apo_router_input_arbiter #(.N2(N2), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_free    (din[0]),
      .in_r1R     (din[1]),
      .in_r2R     (din[2]),
      .in_r1L     (din[3]),
      .in_r2L     (din[4]),
      .out_free   (dout[0]),
      .out_r1R    (dout[1]),
      .out_r2R    (dout[2]),
      .out_r1L    (dout[3]),
      .out_r2L    (dout[4]),
      .fifo_empty (fifo_empty),
      .ovf        (ovf),
      .drop_cnt   (drop_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      ntot++;
      assert (obs === req) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, req);
   endtask

   task automatic idle();
      for (int i = 0; i < 5; i++) din[i] = '0;
   endtask

   // Advance the model by one edge, clock the DUT, then compare everything.
   task automatic step();
      int          g;
      int          nz;
      logic [4:0]  eemp;
      if (rst) begin
         for (int i = 0; i < 5; i++) begin
            mq[i].delete();
            eout[i] = '0;
         end
         rr = 0; eovf = '0; edrop = 0;
      end else begin
         g = -1;
         for (int k = 0; k < 5; k++)
            if (g < 0 && mq[(rr + k) % 5].size() > 0) g = (rr + k) % 5;
         for (int i = 0; i < 5; i++) eout[i] = '0;
         if (g >= 0) begin
            eout[g] = mq[g].pop_front();
            rr = (g + 1) % 5;
         end
         eovf = '0;
         for (int i = 0; i < 5; i++)
            if (din[i][16]) begin
               if (mq[i].size() < DEPTH) mq[i].push_back(din[i]);
               else eovf[i] = 1'b1;
            end
         edrop = edrop + $countones(eovf);
         if (edrop > 255) edrop = 255;
      end
      @(posedge clk); #1;
      nz = 0;
      for (int i = 0; i < 5; i++) begin
         eemp[i] = (mq[i].size() == 0);
         if (dout[i] != '0) nz++;
      end
      chk("out_free", 32'(dout[0]), 32'(eout[0]));
      chk("out_r1R",  32'(dout[1]), 32'(eout[1]));
      chk("out_r2R",  32'(dout[2]), 32'(eout[2]));
      chk("out_r1L",  32'(dout[3]), 32'(eout[3]));
      chk("out_r2L",  32'(dout[4]), 32'(eout[4]));
      chk("ovf",        32'(ovf),        32'(eovf));
      chk("drop_cnt",   32'(drop_cnt),   32'(edrop));
      chk("fifo_empty", 32'(fifo_empty), 32'(eemp));
      chk("onehot", 32'(nz <= 1), 32'd1);
   endtask

   initial begin
      int fwd, drp, nxt;
      rst = 1'b1;
      idle();
      step(); step();
      chk("rst_empty", 32'(fifo_empty), 32'h1F);
      rst = 1'b0;

      // T1: single packet, two cycles from input to output
      din[4] = 17'h1_0302;
      step();
      idle();
      step();
      chk("t1_out", 32'(dout[4]), 32'h1_0302);
      step();
      chk("t1_gone", 32'(dout[4]), 32'h0);
      // invalid packet with payload must be ignored
      din[2] = 17'h0_ABCD;
      step();
      idle();
      repeat (3) step();

      // T2: burst on all five inputs after reset
      rst = 1'b1; step(); rst = 1'b0;
      din[0] = 17'h1_0011; din[1] = 17'h1_0022; din[2] = 17'h1_0033;
      din[3] = 17'h1_0044; din[4] = 17'h1_0055;
      step();
      idle();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t2_seq", 32'(dout[i]), 32'h1_0011 * (i + 1) - 32'h1_0000 * i);
      end
      step();

      // T3: r1R and r1L held valid, fairness and overflow
      for (int c = 0; c < 40; c++) begin
         din[1] = 17'h1_0100 | 17'(c);
         din[3] = 17'h1_0300 | 17'(c);
         step();
      end
      idle();
      repeat (12) step();

      // T4: ten back-to-back packets on in_free
      rst = 1'b1; step(); rst = 1'b0;
      fwd = 0; drp = 0; nxt = 1;
      for (int c = 1; c <= 20; c++) begin
         if (c <= 10) din[0] = 17'h1_0000 | 17'(c);
         else idle();
         step();
         if (dout[0] != '0) begin
            chk("t4_order", 32'(dout[0][15:0]), 32'(nxt));
            nxt++; fwd++;
         end
         if (ovf[0]) drp++;
      end
      chk("t4_total", 32'(fwd + drp), 32'd10);
      chk("t4_drops", 32'(drop_cnt), 32'(drp));

      // T5: saturate the drop counter
      rst = 1'b1; step(); rst = 1'b0;
      for (int c = 0; c < 90; c++) begin
         for (int i = 0; i < 5; i++) din[i] = 17'h1_0000 | 17'((i << 8) | c);
         step();
      end
      chk("t5_sat", 32'(drop_cnt), 32'd255);
      idle();
      repeat (4) step();
      chk("t5_hold", 32'(drop_cnt), 32'd255);

      // T6: reset while several FIFOs hold packets
      rst = 1'b1; step(); rst = 1'b0;
      din[1] = 17'h1_0A01; din[2] = 17'h1_0A02; din[4] = 17'h1_0A04;
      step(); step();
      idle();
      step();
      din[3] = 17'h1_0BAD;        // present during reset: discarded
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_empty", 32'(fifo_empty), 32'h1F);
      chk("t6_drop",  32'(drop_cnt),   32'h0);
      chk("t6_out",   32'(dout[1] | dout[2] | dout[4]), 32'h0);
      din[3] = 17'h1_0C03; din[1] = 17'h1_0C01;
      step();
      idle();
      step();
      chk("t6_first", 32'(dout[1]), 32'h1_0C01);
      step();
      chk("t6_second", 32'(dout[3]), 32'h1_0C03);
      repeat (3) step();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
